// File: rtl/fb_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fb_access_arbiter: shares a single-port framebuffer RAM between scanout    |
// | reads, draw writes and a full-screen clear engine. Rev 1.0                 |
// +--------------------------------------------------------------------------+
module fb_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 19200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear_start,
  input  logic [DATA_W-1:0] clear_color,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic [DATA_W-1:0] clr_color_q, clr_color_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_pend_q, rd_pend_d;
  logic              rd_valid_q, rd_valid_d;
  logic              clear_busy_q, clear_busy_d;
  logic              clear_done_q, clear_done_d;

  logic rd_grant;
  logic wr_fire;
  logic clr_fire;

  // Memory ownership: scanout always wins, then draw (IDLE), then clear (CLEAR).
  always_comb begin
    rd_grant  = rd_req && !rst;
    wr_ready  = !rd_req && (state_q == IDLE) && !rst;
    wr_fire   = wr_valid && wr_ready;
    clr_fire  = !rd_req && (state_q == CLEAR) && !rst;
    mem_we    = wr_fire || clr_fire;
    mem_wdata = clr_fire ? clr_color_q : wr_data;
    if (rst) begin
      mem_addr = '0;
    end else if (rd_grant) begin
      mem_addr = rd_addr;
    end else if (wr_fire) begin
      mem_addr = wr_addr;
    end else if (clr_fire) begin
      mem_addr = clr_addr_q;
    end else begin
      mem_addr = last_addr_q;
    end
    last_addr_d = mem_addr;
  end

  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_color_d  = clr_color_q;
    clear_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d     = CLEAR;
          clr_addr_d  = '0;
          clr_color_d = clear_color;
        end
      end
      CLEAR: begin
        if (clr_fire) begin
          if (clr_addr_q == LAST_ADDR) begin
            state_d      = IDLE;
            clear_done_d = 1'b1;
          end else begin
            clr_addr_d = clr_addr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    clear_busy_d = (state_d == CLEAR);
  end

  // RAM returns data one cycle after the grant; one more register stage here.
  always_comb begin
    rd_pend_d  = rd_grant;
    rd_valid_d = rd_pend_q;
    rd_data_d  = rd_pend_q ? mem_rdata : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      clr_addr_q   <= '0;
      last_addr_q  <= '0;
      clr_color_q  <= '0;
      rd_data_q    <= '0;
      rd_pend_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      last_addr_q  <= last_addr_d;
      clr_color_q  <= clr_color_d;
      rd_data_q    <= rd_data_d;
      rd_pend_q    <= rd_pend_d;
      rd_valid_q   <= rd_valid_d;
      clear_busy_q <= clear_busy_d;
      clear_done_q <= clear_done_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign clear_busy = clear_busy_q;
  assign clear_done = clear_done_q;

endmodule
`default_nettype wire

// File: tb/tb_fb_access_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fb_access_arbiter: directed self-checking bench with a RAM model.       |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_fb_access_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 15;
  localparam int DEPTH  = 19200;

  logic              clk = 1'b0;
  logic              rst;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clear_start;
  logic [DATA_W-1:0] clear_color;
  logic              clear_busy;
  logic              clear_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] ram [DEPTH];
  int reset_writes = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_access_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_start(clear_start), .clear_color(clear_color),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port RAM, one-cycle synchronous read.
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      if (rst) reset_writes <= reset_writes + 1;
    end
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [DATA_W-1:0] init_val(input int a);
    return DATA_W'(a) ^ 8'h5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c, busy, reads, dones, viol, bad;
    for (int i = 0; i < DEPTH; i++) ram[i] = init_val(i);

    // Reset with every request asserted.
    rst = 1'b1; rd_req = 1'b1; rd_addr = 15'd7;
    wr_valid = 1'b1; wr_addr = 15'd3; wr_data = 8'hFF;
    clear_start = 1'b1; clear_color = 8'hAA;
    repeat (3) begin
      tick();
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_wr_ready", 32'(wr_ready), 0);
    end
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_clear_busy", 32'(clear_busy), 0);
    chk("rst_clear_done", 32'(clear_done), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    rst = 1'b0; rd_req = 1'b0; wr_valid = 1'b0; clear_start = 1'b0;
    tick();
    chk("rst_ram_writes", 32'(reset_writes), 0);
    chk("rst_ram_untouched", 32'(ram[3]), 32'(init_val(3)));
    chk("rst_start_ignored", 32'(clear_busy), 0);

    // Write then read back.
    wr_valid = 1'b1; wr_addr = 15'd100; wr_data = 8'hA5;
    settle();
    chk("wr_ready", 32'(wr_ready), 1);
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_mem_addr", 32'(mem_addr), 100);
    tick();
    wr_valid = 1'b0; rd_req = 1'b1; rd_addr = 15'd100;
    settle();
    chk("rd_mem_we", 32'(mem_we), 0);
    tick();
    rd_req = 1'b0;
    settle();
    chk("rd_valid_n1", 32'(rd_valid), 0);
    chk("idle_addr_hold", 32'(mem_addr), 100);
    tick();
    chk("rd_valid_n2", 32'(rd_valid), 1);
    chk("rd_data_n2", 32'(rd_data), 'hA5);

    // Draw write held off by four back-to-back reads.
    for (int i = 0; i < 8; i++) begin
      wr_valid = (i <= 4); wr_addr = 15'd5; wr_data = 8'h3C;
      rd_req = (i < 4); rd_addr = ADDR_W'(10 + i);
      settle();
      if (i < 4) begin
        chk("cont_wr_ready", 32'(wr_ready), 0);
        chk("cont_mem_we", 32'(mem_we), 0);
      end
      if (i == 4) begin
        chk("cont_wr_ready5", 32'(wr_ready), 1);
        chk("cont_mem_we5", 32'(mem_we), 1);
        chk("cont_mem_addr5", 32'(mem_addr), 5);
      end
      if (i >= 2 && i <= 5) begin
        chk("cont_rd_valid", 32'(rd_valid), 1);
        chk("cont_rd_data", 32'(rd_data), 32'(init_val(10 + i - 2)));
      end
      if (i == 6) chk("cont_rd_valid_end", 32'(rd_valid), 0);
      tick();
    end
    wr_valid = 1'b0; rd_req = 1'b0;
    chk("cont_ram5", 32'(ram[5]), 'h3C);

    // Clear with a scanout read every fourth cycle.
    clear_color = 8'h1F; clear_start = 1'b1;
    tick();
    clear_start = 1'b0; clear_color = 8'h00;
    chk("clr_busy_rise", 32'(clear_busy), 1);
    c = 0; busy = 0; reads = 0; dones = 0; viol = 0;
    while (dones == 0 && c < 30000) begin
      c++;
      rd_req = (c % 4 == 0);
      rd_addr = ADDR_W'(c % DEPTH);
      settle();
      if (clear_busy) begin
        busy++;
        if (rd_req) reads++;
        if (wr_ready) viol++;
      end
      if (clear_done) dones++;
      tick();
    end
    rd_req = 1'b0;
    repeat (5) begin
      if (clear_done) dones++;
      tick();
    end
    chk("clr_done_once", 32'(dones), 1);
    chk("clr_duration", 32'(busy), 32'(DEPTH + reads));
    chk("clr_wr_ready_low", 32'(viol), 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[ADDR_W'(i)] !== 8'h1F) bad++;
    chk("clr_ram_fill", 32'(bad), 0);
    rd_req = 1'b1; rd_addr = ADDR_W'(DEPTH - 1);
    tick();
    rd_req = 1'b0;
    tick();
    chk("clr_rd_last_valid", 32'(rd_valid), 1);
    chk("clr_rd_last_data", 32'(rd_data), 'h1F);

    // Abort a clear with reset at cycle 500.
    clear_color = 8'h66; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (499) tick();
    rst = 1'b1;
    settle();
    chk("abort_mem_we", 32'(mem_we), 0);
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(clear_busy), 0);
    dones = 0;
    repeat (5) begin
      if (clear_done) dones++;
      tick();
    end
    chk("abort_no_done", 32'(dones), 0);
    chk("abort_ram498", 32'(ram[498]), 'h66);
    chk("abort_ram499", 32'(ram[499]), 'h1F);
    bad = 0;
    for (int i = 0; i < DEPTH; i++)
      if (ram[ADDR_W'(i)] !== ((i < 499) ? 8'h66 : 8'h1F)) bad++;
    chk("abort_ram_map", 32'(bad), 0);

    // Second clear runs to completion; a mid-clear start is ignored.
    clear_color = 8'hC3; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    c = 0; busy = 0; dones = 0;
    while (dones == 0 && c < 30000) begin
      c++;
      clear_start = (c == 1000);
      clear_color = (c == 1000) ? 8'h00 : 8'hC3;
      settle();
      if (c == 1000) chk("restart_wdata", 32'(mem_wdata), 'hC3);
      if (clear_busy) busy++;
      if (clear_done) dones++;
      tick();
    end
    clear_start = 1'b0;
    repeat (5) begin
      if (clear_done) dones++;
      tick();
    end
    chk("restart_done_once", 32'(dones), 1);
    chk("restart_duration", 32'(busy), 32'(DEPTH));
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[ADDR_W'(i)] !== 8'hC3) bad++;
    chk("restart_ram_fill", 32'(bad), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
